dac_burst_sched: RTL and testbench

- Cycle-deterministic burst scheduler that drives the 14-bit dual-channel DAC front end (dac0, dac1, ce inputs of the DDR DAC interface).
- Pulls synthetic-FRB samples from an upstream valid/ready stream in timed bursts and repeats them every programmed period.
- Holds ce low through a settle window after enable, so the DAC interface stays in reset with zeroed data until the scheduler is running.
- Sits between the pulse generator / sample memory and the DAC interface, in the DAC clock domain.

---
 rtl/dac_burst_sched_if.sv | 16 +
 rtl/dac_burst_sched.sv | 165 ++++++++++++++++
 tb/tb_dac_burst_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dac_burst_sched_if.sv
// rtl/dac_burst_sched_if.sv - upstream sample stream and DAC front-end bundle for dac_burst_sched
interface dac_burst_sched_if #(
    parameter int DATA_WIDTH = 14
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_dat0;
    logic [DATA_WIDTH-1:0] s_dat1;
    logic [DATA_WIDTH-1:0] dac0;
    logic [DATA_WIDTH-1:0] dac1;
    logic                  dac_ce;

    // master: sample source / DAC observer side; slave: the scheduler
    modport master (output s_valid, s_dat0, s_dat1, input s_ready, dac0, dac1, dac_ce);
    modport slave  (input s_valid, s_dat0, s_dat1, output s_ready, dac0, dac1, dac_ce);
endinterface

// File: rtl/dac_burst_sched.sv
// rtl/dac_burst_sched.sv - timed burst scheduler feeding the DDR DAC front end
// Optional: DAC_BURST_SCHED_HOLD_EN repeats the last valid sample on an underflowed slot.
module dac_burst_sched #(
    parameter int DATA_WIDTH    = 14,
    parameter int CNT_WIDTH     = 32,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] burst_len,
    input  logic                 underflow_clr,
    output logic                 burst_active,
    output logic                 underflow,
    output logic [CNT_WIDTH-1:0] burst_cnt,
    dac_burst_sched_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, BURST, GAP} state_t;

    localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ONE         = CNT_WIDTH'(1);

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0] per_q, len_q;
    logic                 burst_start;
    logic                 cnt_zero;
    logic                 slot;
    logic                 gap_en;
    logic [CNT_WIDTH-1:0] gap_load, len_load;
    logic [DATA_WIDTH-1:0] fill0, fill1;

    assign cnt_zero = (cnt == '0);
    assign slot     = (state == BURST) && enable;
    assign gap_en   = (per_q > len_q);
    assign gap_load = per_q - len_q - ONE;
    assign len_load = len_q - ONE;

    // cnt holds remaining cycles of the current phase minus one; each phase exits on zero
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt_zero ? cnt : cnt - ONE;
        burst_start = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = SETTLE;
                    cnt_nxt   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (cnt_zero) begin
                    if (len_q == '0) begin
                        state_nxt = GAP;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt   = BURST;
                        cnt_nxt     = len_load;
                        burst_start = 1'b1;
                    end
                end
            end
            BURST: begin
                if (cnt_zero) begin
                    if (gap_en) begin
                        state_nxt = GAP;
                        cnt_nxt   = gap_load;
                    end else begin
                        state_nxt   = BURST;
                        cnt_nxt     = len_load;
                        burst_start = 1'b1;
                    end
                end
            end
            GAP: begin
                // zero-length bursts park here for good
                if (cnt_zero && (len_q != '0)) begin
                    state_nxt   = BURST;
                    cnt_nxt     = len_load;
                    burst_start = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!enable) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            burst_start = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            per_q <= '0;
            len_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if ((state == IDLE) && enable) begin
                per_q <= period;
                len_q <= burst_len;
            end
        end
    end

`ifdef DAC_BURST_SCHED_HOLD_EN
    logic [DATA_WIDTH-1:0] hold0, hold1;

    // burst start wins over a valid last slot of the previous back-to-back burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0 <= '0;
            hold1 <= '0;
        end else if ((state == IDLE) || burst_start) begin
            hold0 <= '0;
            hold1 <= '0;
        end else if (slot && bus.s_valid) begin
            hold0 <= bus.s_dat0;
            hold1 <= bus.s_dat1;
        end
    end

    assign fill0 = hold0;
    assign fill1 = hold1;
`else
    assign fill0 = '0;
    assign fill1 = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.s_ready  <= 1'b0;
            bus.dac_ce   <= 1'b0;
            bus.dac0     <= '0;
            bus.dac1     <= '0;
            burst_active <= 1'b0;
            underflow    <= 1'b0;
            burst_cnt    <= '0;
        end else begin
            bus.s_ready  <= (state_nxt == BURST);
            burst_active <= (state_nxt == BURST);
            bus.dac_ce   <= (state_nxt == BURST) || (state_nxt == GAP);
            if (slot) begin
                bus.dac0 <= bus.s_valid ? bus.s_dat0 : fill0;
                bus.dac1 <= bus.s_valid ? bus.s_dat1 : fill1;
            end else begin
                bus.dac0 <= '0;
                bus.dac1 <= '0;
            end
            if (slot && !bus.s_valid) begin
                underflow <= 1'b1;
            end else if (underflow_clr) begin
                underflow <= 1'b0;
            end
            if ((state == IDLE) && enable) begin
                burst_cnt <= '0;
            end else if (burst_start && (burst_cnt != '1)) begin
                burst_cnt <= burst_cnt + ONE;
            end
        end
    end
endmodule

// File: tb/tb_dac_burst_sched.sv
// tb/tb_dac_burst_sched.sv - randomized bench for dac_burst_sched against a timeline model
module tb_dac_burst_sched;
    localparam int DW = 14;
    localparam int CW = 32;
    localparam int S  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          underflow_clr = 1'b0;
    logic [CW-1:0] period = '0;
    logic [CW-1:0] burst_len = '0;
    logic          burst_active;
    logic          underflow;
    logic [CW-1:0] burst_cnt;

    dac_burst_sched_if #(.DATA_WIDTH(DW)) bus ();

    dac_burst_sched #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .period       (period),
        .burst_len    (burst_len),
        .underflow_clr(underflow_clr),
        .burst_active (burst_active),
        .underflow    (underflow),
        .burst_cnt    (burst_cnt),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ramp   = 1;

    // model: timeline position m_t counts cycles since the first settle cycle
    bit          m_run = 0;
    int          m_t   = 0;
    int          m_per = 0;
    int          m_len = 0;
    logic [DW-1:0] m_d0 = '0, m_d1 = '0, m_h0 = '0, m_h1 = '0;
    bit          m_uf  = 0;
    int          m_bcnt = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, m_t);
        end
    endtask

    function automatic int eff();
        return (m_per > m_len) ? m_per : m_len;
    endfunction

    function automatic bit in_burst(input int t);
        if (t < S || m_len == 0) return 1'b0;
        return ((t - S) % eff()) < m_len;
    endfunction

    function automatic int bursts(input int t);
        if (t < S || m_len == 0) return 0;
        return (t - S) / eff() + 1;
    endfunction

    task automatic model_step();
        bit ib;
        bit slot;
        ib   = m_run && in_burst(m_t);
        slot = ib && enable;
        if (slot) begin
            if (((m_t - S) % eff()) == 0) begin
                m_h0 = '0;
                m_h1 = '0;
            end
            if (bus.s_valid) begin
                m_d0 = bus.s_dat0;
                m_d1 = bus.s_dat1;
                m_h0 = bus.s_dat0;
                m_h1 = bus.s_dat1;
            end else begin
`ifdef DAC_BURST_SCHED_HOLD_EN
                m_d0 = m_h0;
                m_d1 = m_h1;
`else
                m_d0 = '0;
                m_d1 = '0;
`endif
                m_uf = 1'b1;
            end
        end else begin
            m_d0 = '0;
            m_d1 = '0;
        end
        if (!(slot && !bus.s_valid) && underflow_clr) m_uf = 1'b0;
        if (!enable) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run = 1'b1;
            m_t   = 0;
            m_per = int'(period);
            m_len = int'(burst_len);
        end else begin
            m_t++;
        end
        if (m_run) m_bcnt = bursts(m_t);
    endtask

    task automatic check_outputs();
        chk("dac0", 64'(bus.dac0), 64'(m_d0));
        chk("dac1", 64'(bus.dac1), 64'(m_d1));
        chk("dac_ce", 64'(bus.dac_ce), 64'(m_run && m_t >= S));
        chk("s_ready", 64'(bus.s_ready), 64'(m_run && in_burst(m_t)));
        chk("burst_active", 64'(burst_active), 64'(m_run && in_burst(m_t)));
        chk("underflow", 64'(underflow), 64'(m_uf));
        chk("burst_cnt", 64'(burst_cnt), 64'(m_bcnt));
    endtask

    // modes: 0 clean ramp, 1 random underflow, 2 back-to-back, 3 zero length, 4 random all, 5 disabled
    task automatic drive(input int mode);
        ramp++;
        bus.s_dat0 = DW'(ramp);
        bus.s_dat1 = DW'(ramp * 3 + 5);
        bus.s_valid = (mode == 1 || mode == 4 || mode == 5) ? ($urandom_range(0, 3) != 0) : 1'b1;
        underflow_clr = (mode == 1 || mode == 4) ? ($urandom_range(0, 7) == 0) : 1'b0;
        period    = CW'($urandom_range(0, 12));
        burst_len = CW'($urandom_range(0, 6));
        if (mode == 5)      enable = 1'b0;
        else if (mode == 4) enable = ($urandom_range(0, 39) != 0);
        else                enable = 1'b1;
    endtask

    task automatic run_seg(input int mode, input int per, input int len, input int n);
        period    = CW'(per);
        burst_len = CW'(len);
        enable    = (mode != 5);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_outputs();
            drive(mode);
        end
    endtask

    initial begin
        bus.s_valid = 1'b1;
        bus.s_dat0  = DW'(1);
        bus.s_dat1  = DW'(8);
        enable      = 1'b1;
        period      = CW'(10);
        burst_len   = CW'(4);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs();
        end
        enable = 1'b0;
        rst_n  = 1'b1;

        run_seg(0, 10, 4, 70);
        run_seg(5, 0, 0, 3);
        run_seg(1, 10, 4, 120);
        run_seg(5, 0, 0, 3);
        run_seg(2, 3, 5, 80);
        run_seg(5, 0, 0, 3);
        run_seg(3, 7, 0, 40);
        run_seg(5, 0, 0, 3);
        run_seg(4, 9, 3, 1000);
        run_seg(5, 0, 0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
